// File: rtl/mem_bus_if.sv
// mem_bus_if: Wishbone classic master bridge between the MEM stage and the data bus.
//
// A MEM-stage load/store request becomes exactly one Wishbone classic cycle. The pipeline
// is held through stallreq_o until the slave acknowledges. Controller stall/flush are
// obeyed so that an access is never lost or issued twice.
//
// Ports:
//   clk, rst                     clock (rising edge), synchronous active-high reset
//   stall_i, flush_i             controller stall vector and flush
//   cpu_ce_i/we_i/addr_i/data_i/sel_i   MEM-stage request
//   cpu_data_o                   load data to MEM stage (combinational)
//   stallreq_o                   pipeline hold request (combinational)
//   wb_adr_o/dat_o/we_o/sel_o/stb_o/cyc_o   registered Wishbone master drives
//   wb_dat_i, wb_ack_i           Wishbone slave response
//   bus_err_o                    one-cycle ack-timeout pulse (only with MEM_BUS_TIMEOUT_EN)
//
// Build option: define MEM_BUS_TIMEOUT_EN to abandon a cycle that sees no ack within
// TIMEOUT_CYCLES BUSY cycles. Without it BUSY waits for ack indefinitely.
module mem_bus_if #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  localparam int unsigned SEL_W         = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall_i,
  input  logic              flush_i,
  input  logic              cpu_ce_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  input  logic [SEL_W-1:0]  cpu_sel_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              stallreq_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic              wb_we_o,
  output logic [SEL_W-1:0]  wb_sel_o,
  output logic              wb_stb_o,
  output logic              wb_cyc_o,
  input  logic              wb_ack_i
`ifdef MEM_BUS_TIMEOUT_EN
  ,
  output logic              bus_err_o
`endif
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("mem_bus_if: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StHold} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] rdbuf_q;
  logic              timeout;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  logic [CntW-1:0] cnt_q;

  // Counter holds the number of ack-less BUSY cycles already elapsed.
  assign timeout = (state_q == StBusy) && !wb_ack_i &&
                   (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      rdbuf_q  <= '0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_we_o  <= 1'b0;
      wb_sel_o <= '0;
      wb_stb_o <= 1'b0;
      wb_cyc_o <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
      cnt_q     <= '0;
      bus_err_o <= 1'b0;
`endif
    end else begin
`ifdef MEM_BUS_TIMEOUT_EN
      bus_err_o <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (cpu_ce_i && !flush_i) begin
            wb_adr_o <= cpu_addr_i;
            wb_dat_o <= cpu_data_i;
            wb_we_o  <= cpu_we_i;
            wb_sel_o <= cpu_sel_i;
            wb_stb_o <= 1'b1;
            wb_cyc_o <= 1'b1;
            state_q  <= StBusy;
`ifdef MEM_BUS_TIMEOUT_EN
            cnt_q    <= '0;
`endif
          end
        end
        StBusy: begin
          if (flush_i || wb_ack_i || timeout) begin
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
          end
          // Flush wins over ack; ack wins over timeout.
          if (flush_i) begin
            rdbuf_q <= '0;
            state_q <= StIdle;
          end else if (wb_ack_i) begin
            if (!wb_we_o) rdbuf_q <= wb_dat_i;
            // Keep the result visible while the pipeline is still frozen.
            state_q <= (stall_i != '0) ? StHold : StIdle;
          end else if (timeout) begin
            state_q <= StIdle;
`ifdef MEM_BUS_TIMEOUT_EN
            bus_err_o <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
`endif
          end
        end
        StHold: begin
          if (flush_i) begin
            rdbuf_q <= '0;
            state_q <= StIdle;
          end else if (stall_i == '0) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    stallreq_o = 1'b0;
    cpu_data_o = '0;
    if (!rst) begin
      unique case (state_q)
        StIdle: stallreq_o = cpu_ce_i & ~flush_i;
        StBusy: begin
          stallreq_o = ~wb_ack_i & ~flush_i & ~timeout;
          // A flushed ack is discarded, so its data is not forwarded either.
          if (wb_ack_i && !flush_i) cpu_data_o = wb_dat_i;
        end
        StHold: cpu_data_o = rdbuf_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_if.sv
// Randomized bench for mem_bus_if against a transaction-level reference model.
module tb_mem_bus_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned TO     = 8;
  localparam int unsigned NCYC   = 4000;

  logic              clk = 1'b0;
  logic              rst;
  logic [5:0]        stall;
  logic              flush, ce, we, ack;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, rdata_bus;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] cpu_data;
  logic              stallreq;
  logic [ADDR_W-1:0] wb_adr;
  logic [DATA_W-1:0] wb_dat;
  logic              wb_we, wb_stb, wb_cyc;
  logic [SEL_W-1:0]  wb_sel;
`ifdef MEM_BUS_TIMEOUT_EN
  logic              bus_err;
`endif

  always #5 clk = ~clk;

  mem_bus_if #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall_i(stall),
    .flush_i(flush),
    .cpu_ce_i(ce),
    .cpu_we_i(we),
    .cpu_addr_i(addr),
    .cpu_data_i(wdata),
    .cpu_sel_i(sel),
    .cpu_data_o(cpu_data),
    .stallreq_o(stallreq),
    .wb_adr_o(wb_adr),
    .wb_dat_o(wb_dat),
    .wb_dat_i(rdata_bus),
    .wb_we_o(wb_we),
    .wb_sel_o(wb_sel),
    .wb_stb_o(wb_stb),
    .wb_cyc_o(wb_cyc),
    .wb_ack_i(ack)
`ifdef MEM_BUS_TIMEOUT_EN
    ,
    .bus_err_o(bus_err)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: an outstanding transaction, a delivered-but-stalled result, or nothing.
  bit              m_out = 0;
  bit              m_hold = 0;
  logic [ADDR_W-1:0] m_adr = '0;
  logic [DATA_W-1:0] m_dat = '0;
  bit              m_we = 0;
  logic [SEL_W-1:0] m_sel = '0;
  logic [DATA_W-1:0] m_buf = '0;
  int              m_wait = 0;
  bit              m_err = 0;
  int              issued = 0;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  // Apply one clock edge to the model using the inputs present at that edge.
  task automatic model_step();
    m_err = 0;
    if (rst) begin
      m_out = 0; m_hold = 0; m_buf = '0; m_wait = 0;
    end else if (m_out) begin
      if (flush) begin
        m_out = 0; m_buf = '0;
      end else if (ack) begin
        if (!m_we) m_buf = rdata_bus;
        m_out = 0;
        m_hold = (stall != 0);
      end else if (TmoEn && m_wait == TO - 1) begin
        m_out = 0; m_err = 1;
      end else begin
        m_wait++;
      end
    end else if (m_hold) begin
      if (flush) begin
        m_hold = 0; m_buf = '0;
      end else if (stall == 0) begin
        m_hold = 0;
      end
    end else if (ce && !flush) begin
      m_out = 1; m_wait = 0; issued++;
      m_adr = addr; m_dat = wdata; m_we = we; m_sel = sel;
    end
  endtask

  task automatic check_all();
    logic             e_req;
    logic [DATA_W-1:0] e_data;
    bit               tmo;
    e_req = 0;
    e_data = '0;
    if (!rst) begin
      if (m_out) begin
        tmo = TmoEn && !ack && (m_wait == TO - 1);
        e_req = !ack && !flush && !tmo;
        if (ack && !flush) e_data = rdata_bus;
      end else if (m_hold) begin
        e_data = m_buf;
      end else begin
        e_req = ce && !flush;
      end
    end
    check("stallreq", 64'(stallreq), 64'(e_req));
    check("cpu_data", 64'(cpu_data), 64'(e_data));
    check("wb_stb", 64'(wb_stb), 64'(m_out));
    check("wb_cyc", 64'(wb_cyc), 64'(m_out));
    check("wb_adr", 64'(wb_adr), m_out ? 64'(m_adr) : 64'd0);
    check("wb_dat", 64'(wb_dat), m_out ? 64'(m_dat) : 64'd0);
    check("wb_we", 64'(wb_we), m_out ? 64'(m_we) : 64'd0);
    check("wb_sel", 64'(wb_sel), m_out ? 64'(m_sel) : 64'd0);
`ifdef MEM_BUS_TIMEOUT_EN
    check("bus_err", 64'(bus_err), 64'(m_err));
`endif
  endtask

  function automatic bit pct(input int p);
    return $urandom_range(99) < p;
  endfunction

  initial begin
    int ack_pct, stall_pct, flush_pct, rst_pct;
    rst = 1; stall = '0; flush = 0; ce = 0; we = 0; ack = 0;
    addr = '0; wdata = '0; sel = '0; rdata_bus = '0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      model_step();
      // Phases vary the slave speed and controller activity.
      unique case ((c / 500) % 4)
        0: begin ack_pct = 100; stall_pct = 20; flush_pct = 3; rst_pct = 1; end
        1: begin ack_pct = 30;  stall_pct = 40; flush_pct = 3; rst_pct = 1; end
        2: begin ack_pct = 5;   stall_pct = 30; flush_pct = 2; rst_pct = 1; end
        default: begin ack_pct = 0; stall_pct = 30; flush_pct = 2; rst_pct = 1; end
      endcase
      rst = (c < 3) || pct(rst_pct);
      ce = pct(60);
      we = pct(50);
      addr = $urandom;
      wdata = $urandom;
      sel = SEL_W'($urandom);
      stall = pct(stall_pct) ? 6'($urandom_range(63, 1)) : 6'd0;
      flush = pct(flush_pct);
      ack = pct(ack_pct);
      rdata_bus = $urandom;
      #1;
      check_all();
    end
    if (issued < 50) begin
      failures++;
      $display("FAIL issued: got %0d expected at least 50", issued);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_if.md
Name: mem_bus_if

Overview:
- Wishbone master bridge between the MEM stage and the data bus.
- Turns a MEM-stage load/store request into a single Wishbone classic cycle.
- Holds the pipeline by asserting `stallreq_o`, which drives the controller's `stallreq_from_mem` input, until the transfer completes.
- Obeys the controller's `stall` vector and `flush` so that no access is lost or duplicated around stalls and exceptions.

Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; `SEL_W` = `DATA_W`/8.
- `TIMEOUT_CYCLES`, 256, ack wait limit. Used only with `MEM_BUS_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stall_i`  in  6  controller stall vector.
- `flush_i`  in  1  controller flush.
- `cpu_ce_i`  in  1  MEM-stage access request.
- `cpu_we_i`  in  1  1 = store, 0 = load.
- `cpu_addr_i`  in  `ADDR_W`  byte address.
- `cpu_data_i`  in  `DATA_W`  store data.
- `cpu_sel_i`  in  `SEL_W`  byte enables.
- `cpu_data_o`  out  `DATA_W`  load data to MEM stage.
- `stallreq_o`  out  1  pipeline hold request.
- `wb_adr_o`  out  `ADDR_W`  bus address.
- `wb_dat_o`  out  `DATA_W`  bus write data.
- `wb_dat_i`  in  `DATA_W`  bus read data.
- `wb_we_o`  out  1  bus write enable.
- `wb_sel_o`  out  `SEL_W`  bus byte select.
- `wb_stb_o`  out  1  strobe.
- `wb_cyc_o`  out  1  cycle.
- `wb_ack_i`  in  1  acknowledge.
- `bus_err_o`  out  1  timeout pulse. Exists only with `MEM_BUS_TIMEOUT_EN`.

Behaviour:
- **Reset.** State = IDLE; all `wb_*_o` = 0; read buffer = 0; `bus_err_o` = 0.
  - `cpu_data_o` and `stallreq_o` are combinational and read 0 while `rst` = 1.
- **States.** IDLE, BUSY, HOLD. Bus outputs are registered.
- **IDLE:**
  - If `cpu_ce_i` = 1 and `flush_i` = 0, register the bus drives:
    - `wb_adr_o` = `cpu_addr_i`, `wb_dat_o` = `cpu_data_i`, `wb_we_o` = `cpu_we_i`, `wb_sel_o` = `cpu_sel_i`;
    - `wb_stb_o` = `wb_cyc_o` = 1;
    - go to BUSY.
  - Otherwise stay in IDLE with `stb`/`cyc` = 0.
- **BUSY, `wb_ack_i` = 1:**
  - Next cycle `stb`, `cyc`, `we`, `sel` = 0 and `adr`/`dat` = 0.
  - If the access is a load (`wb_we_o` = 0), the buffer captures `wb_dat_i`.
  - Go to HOLD if `stall_i` != 0, else go to IDLE.
- **BUSY, no ack:** hold every bus output stable.
- **HOLD:** return to IDLE on the first cycle with `stall_i` = 0.
- **Flush.** `flush_i` = 1 in BUSY or HOLD forces:
  - bus outputs to 0 and the buffer to 0;
  - next state IDLE.
  - Any ack in the same cycle is discarded.
  - Flush has priority over ack, and `rst` has priority over everything.
- **`stallreq_o` (combinational):**
  - IDLE: `cpu_ce_i` & ~`flush_i`.
  - BUSY: ~`wb_ack_i` & ~`flush_i`.
  - HOLD: 0.
- **`cpu_data_o` (combinational):**
  - BUSY with `wb_ack_i` = 1: `wb_dat_i`.
  - HOLD: the buffer.
  - Otherwise 0.
- **Latency.** Request seen in cycle N drives the bus in N+1. With a zero-wait slave, ack arrives in N+1 and `stallreq_o` = 1 only during cycle N.
- **Ordering.** One outstanding cycle at most. A new request is accepted only from IDLE, so a stalled MEM stage holding `cpu_ce_i` high does not reissue the access.
- **Stray ack.** An ack in IDLE or HOLD is ignored.

Optional Feature:
- **Macro `MEM_BUS_TIMEOUT_EN` defined:**
  - A counter clears on BUSY entry and increments each BUSY cycle without ack.
  - On reaching `TIMEOUT_CYCLES`-1, the block drops `stb`/`cyc`, pulses `bus_err_o` for one cycle, forces `cpu_data_o` to 0 for that cycle and goes to IDLE.
  - `stallreq_o` = 0 in that cycle.
  - The counter and `bus_err_o` reset to 0.
- **Undefined:** no counter and no `bus_err_o` port; BUSY waits for ack indefinitely.

Test Plan:
- **Zero-wait load.** Load addr 0x0000_0100, sel 0xF, slave acks next cycle with 0xDEAD_BEEF → `stallreq_o` high exactly 1 cycle; `cpu_data_o` = 0xDEAD_BEEF in the ack cycle; `stb`/`cyc` low the following cycle.
- **Store with wait states.** Store 0x1234_5678 to 0x0000_0200, sel 0x3, ack after 3 wait states → bus fields stable for 4 cycles; `stallreq_o` = 1 for 4 cycles; exactly one `stb` cycle.
- **Load held by a later stall.** Load completes with 0xCAFE_F00D while `stall_i` = 6'b001111 for 2 more cycles and `cpu_ce_i` stays 1 → state HOLD; `cpu_data_o` = 0xCAFE_F00D both cycles; no second bus cycle issued.
- **Flush mid-transaction.** `flush_i` = 1 in the 2nd BUSY cycle, with ack in the same cycle → `stb`/`cyc` = 0 next cycle; `cpu_data_o` = 0; state IDLE; buffer = 0.
- **Reset mid-transaction.** `rst` asserted during BUSY → all outputs 0 next edge; state IDLE; a subsequent request issues normally.
- **Timeout (`MEM_BUS_TIMEOUT_EN` defined, `TIMEOUT_CYCLES` = 8).** Slave never acks → `bus_err_o` pulses once after 8 BUSY cycles; `stb`/`cyc` drop; `stallreq_o` falls.
